// File: rtl/tych_ing_port_arb_pkg.sv
// Shared types for the ingress port arbiter: core beat format, arbiter FSM state
// and the default ingress port count.
package tych_ing_port_arb_pkg;

  localparam int unsigned NUM_ING_PORTS = 4;
  localparam int unsigned CORE_DATA_W   = 64;
  localparam int unsigned CORE_EMPTY_W  = 3;
  localparam int unsigned FRM_DBG_ID_W  = 16;

  typedef struct packed {
    logic                    valid;
    logic [CORE_DATA_W-1:0]  data;
    logic                    sop;
    logic                    eop;
    logic [CORE_EMPTY_W-1:0] empty;
    logic                    error;
    logic [FRM_DBG_ID_W-1:0] frm_dbg_id;
  } core_avl_t;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } tych_ing_arb_state_e;

endpackage

// File: rtl/tych_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping modulo N.
module tych_rr_pick #(
  parameter int unsigned N      = 4,
  parameter int unsigned PORT_W = $clog2(N)
) (
  input  logic [N-1:0]      req,
  input  logic [PORT_W-1:0] last,
  output logic [PORT_W-1:0] grant_idx,
  output logic              any
);

  int idx;

  // Scan farthest-first so the nearest requester after 'last' is the final write.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int off = int'(N); off >= 1; off--) begin
      idx = (int'(last) + off) % int'(N);
      if (req[idx]) begin
        grant_idx = PORT_W'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tych_ing_port_arb.sv
// Frame-atomic round-robin merge of NUM_PORTS ingress streams into one core stream,
// tagging each beat with its source port and dropping orphan beats while idle.
module tych_ing_port_arb
  import tych_ing_port_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_ING_PORTS,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS),
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  core_avl_t            in_avl [NUM_PORTS],
  output logic [NUM_PORTS-1:0] in_ready,
  input  logic [NUM_PORTS-1:0] port_en,
  output core_avl_t            out_avl,
  output logic [PORT_W-1:0]    out_src,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     orphan_cnt,
  output logic                 busy
);

  tych_ing_arb_state_e  state;
  logic [PORT_W-1:0]    grant;
  logic [PORT_W-1:0]    last_grant;
  logic [PORT_W-1:0]    pick_idx;
  logic                 pick_any;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] orphan;
  logic                 can_load;
  logic                 xfer;
  core_avl_t            cur;

  tych_rr_pick #(
    .N      (NUM_PORTS),
    .PORT_W (PORT_W)
  ) u_pick (
    .req       (req),
    .last      (last_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    req    = '0;
    orphan = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      req[i]    = in_avl[i].valid & in_avl[i].sop & port_en[i];
      orphan[i] = in_avl[i].valid & ~in_avl[i].sop;
    end
  end

  assign can_load = ~out_avl.valid | out_ready;
  assign cur      = in_avl[grant];
  assign busy     = (state == StBusy);

  // Nothing is accepted while reset is held, so no beat is silently swallowed.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      if (state == StBusy) begin
        in_ready[grant] = can_load;
      end else begin
        in_ready = orphan;
      end
    end
  end

  assign xfer = ~rst & (state == StBusy) & cur.valid & can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      grant      <= '0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      out_avl    <= '0;
      out_src    <= '0;
      orphan_cnt <= '0;
    end else begin
      // Output register drains even in idle so the eop beat is not repeated.
      if (xfer) begin
        out_avl <= cur;
        out_src <= grant;
      end else if (can_load) begin
        out_avl.valid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if ((|orphan) && !(&orphan_cnt)) begin
            orphan_cnt <= orphan_cnt + CNT_W'(1);
          end
          if (pick_any) begin
            grant      <= pick_idx;
            last_grant <= pick_idx;
            state      <= StBusy;
          end
        end
        StBusy: begin
          if (xfer && cur.eop) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Mid-frame only the granted port may see ready.
  a_onehot_ready: assert property (@(posedge clk) disable iff (rst) busy |-> $onehot0(in_ready));
  a_grant_range: assert property (@(posedge clk) disable iff (rst) 32'(grant) < NUM_PORTS);

endmodule

// File: tb/tb_tych_ing_port_arb.sv
// Bench for tych_ing_port_arb: directed scenarios plus randomized frames checked
// against a frame-level round-robin schedule model.
module tb_tych_ing_port_arb;
  import tych_ing_port_arb_pkg::*;

  localparam int unsigned NP = 4;

  logic            clk = 1'b0;
  logic            rst;
  core_avl_t       in_avl [NP];
  logic [NP-1:0]   in_ready;
  logic [NP-1:0]   port_en;
  core_avl_t       out_avl;
  logic [1:0]      out_src;
  logic            out_ready;
  logic [15:0]     orphan_cnt;
  logic            busy;

  always #5 clk = ~clk;

  tych_ing_port_arb #(
    .NUM_PORTS (NP),
    .PORT_W    (2),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_avl     (in_avl),
    .in_ready   (in_ready),
    .port_en    (port_en),
    .out_avl    (out_avl),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .orphan_cnt (orphan_cnt),
    .busy       (busy)
  );

  core_avl_t  src_q [NP][$];
  core_avl_t  mdl_q [NP][$];
  core_avl_t  got_q[$];
  logic [1:0] got_src[$];
  core_avl_t  exp_q[$];
  logic [1:0] exp_src[$];

  logic [NP-1:0] s_in_ready;
  core_avl_t     s_out;
  logic [1:0]    s_src;
  logic          s_busy;
  logic [15:0]   s_cnt;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;
  logic rdy_val = 1'b1;
  int   tag = 0;

  task automatic apply_inputs();
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) in_avl[i] = src_q[i][0];
      else in_avl[i] = '0;
    end
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : rdy_val;
  endtask

  // One clock: sample at negedge, retire accepted beats after posedge, drive next inputs.
  task automatic step();
    logic [NP-1:0] acc;
    @(negedge clk);
    s_in_ready = in_ready;
    s_out      = out_avl;
    s_src      = out_src;
    s_busy     = busy;
    s_cnt      = orphan_cnt;
    for (int i = 0; i < NP; i++) acc[i] = in_avl[i].valid & in_ready[i];
    if (out_avl.valid && out_ready) begin
      got_q.push_back(out_avl);
      got_src.push_back(out_src);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    apply_inputs();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    got_q.delete();
    got_src.delete();
    exp_q.delete();
    exp_src.delete();
  endtask

  task automatic do_reset();
    clear_all();
    rand_ready = 1'b0;
    rdy_val    = 1'b1;
    port_en    = '1;
    rst        = 1'b1;
    apply_inputs();
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    got_src.delete();
  endtask

  task automatic add_frame(input int p, input int len, input bit mid_sop);
    core_avl_t b;
    for (int i = 0; i < len; i++) begin
      b            = '0;
      b.valid      = 1'b1;
      b.data       = {$urandom(), $urandom()};
      b.sop        = (i == 0) || (mid_sop && $urandom_range(0, 5) == 0);
      b.eop        = (i == len - 1);
      b.empty      = b.eop ? 3'($urandom_range(0, 7)) : 3'd0;
      b.error      = b.eop & 1'($urandom_range(0, 1));
      b.frm_dbg_id = 16'(tag);
      src_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
    tag++;
  endtask

  // Frame-level schedule: every pending port requests at each arbitration point.
  task automatic build_expected(input int start_last);
    core_avl_t b;
    int        last;
    int        p;
    bit        found;
    last = start_last;
    exp_q.delete();
    exp_src.delete();
    do begin
      found = 1'b0;
      for (int off = 1; off <= NP && !found; off++) begin
        p = (last + off) % NP;
        if (mdl_q[p].size() > 0) begin
          found = 1'b1;
          last  = p;
          do begin
            b = mdl_q[p].pop_front();
            exp_q.push_back(b);
            exp_src.push_back(p[1:0]);
          end while (!b.eop);
        end
      end
    end while (found);
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < budget) begin
      step();
      cyc++;
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_cmp++;
    if (s_out !== '0) begin
      n_err++;
      $display("FAIL reset_out_avl: got %h, want 0", s_out);
    end
    n_cmp++;
    if (s_src !== 2'd0) begin
      n_err++;
      $display("FAIL reset_out_src: got %0d, want 0", s_src);
    end
    n_cmp++;
    if (s_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b, want 0", s_busy);
    end
    n_cmp++;
    if (s_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_orphan_cnt: got %0d, want 0", s_cnt);
    end
    n_cmp++;
    if (s_in_ready !== 4'b0) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, want 0000", s_in_ready);
    end
  endtask

  task automatic test_single_port();
    core_avl_t fr[$];
    do_reset();
    add_frame(0, 3, 1'b0);
    fr = mdl_q[0];
    apply_inputs();
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 2) begin
        n_cmp++;
        if (s_in_ready[0] !== (k == 1) || s_busy !== (k == 1) || s_out.valid !== 1'b0) begin
          n_err++;
          $display("FAIL single_arb[%0d]: got rdy %b busy %b vld %b, want rdy %b busy %b vld 0",
                   k, s_in_ready[0], s_busy, s_out.valid, k == 1, k == 1);
        end
      end else if (k < 5) begin
        n_cmp++;
        if (s_out !== fr[k-2] || s_src !== 2'd0) begin
          n_err++;
          $display("FAIL single_beat[%0d]: got %h src %0d, want %h src 0",
                   k - 2, s_out, s_src, fr[k-2]);
        end
      end else begin
        n_cmp++;
        if (s_out.valid !== 1'b0 || s_busy !== 1'b0) begin
          n_err++;
          $display("FAIL single_tail: got vld %b busy %b, want 0 0", s_out.valid, s_busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < NP; p++) add_frame(p, 2, 1'b0);
    build_expected(NP - 1);
    apply_inputs();
    drain(60);
    // Last grant was port 3, so port 0 must beat port 3 next time.
    add_frame(3, 1, 1'b0);
    add_frame(0, 1, 1'b0);
    exp_q.push_back(mdl_q[0][0]);
    exp_src.push_back(2'd0);
    exp_q.push_back(mdl_q[3][0]);
    exp_src.push_back(2'd3);
    mdl_q[0].delete();
    mdl_q[3].delete();
    apply_inputs();
    drain(30);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rr_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k] || got_src[k] !== exp_src[k]) begin
        n_err++;
        $display("FAIL rr_beat[%0d]: got %h src %0d, want %h src %0d",
                 k, got_q[k], got_src[k], exp_q[k], exp_src[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    core_avl_t held;
    int        cyc;
    do_reset();
    add_frame(0, 6, 1'b0);
    build_expected(NP - 1);
    apply_inputs();
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!s_out.valid && cyc < 10);
    rdy_val   = 1'b0;
    out_ready = 1'b0;
    held      = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) held = s_out;
      n_cmp++;
      if (s_out !== held || s_out.valid !== 1'b1 || s_in_ready[0] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got %h rdy %b, want %h rdy 0",
                 k, s_out, s_in_ready[0], held);
      end
    end
    rdy_val   = 1'b1;
    out_ready = 1'b1;
    drain(40);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bp_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k] || got_src[k] !== exp_src[k]) begin
        n_err++;
        $display("FAIL bp_beat[%0d]: got %h src %0d, want %h src %0d",
                 k, got_q[k], got_src[k], exp_q[k], exp_src[k]);
      end
    end
  endtask

  task automatic test_orphan();
    core_avl_t b;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      b       = '0;
      b.valid = 1'b1;
      b.data  = {$urandom(), $urandom()};
      src_q[2].push_back(b);
    end
    apply_inputs();
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (s_in_ready[2] !== 1'b1 || s_out.valid !== 1'b0) begin
        n_err++;
        $display("FAIL orphan_drop[%0d]: got rdy %b vld %b, want rdy 1 vld 0",
                 k, s_in_ready[2], s_out.valid);
      end
    end
    step();
    n_cmp++;
    if (s_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL orphan_cnt: got %0d, want 5", s_cnt);
    end
  endtask

  task automatic test_disabled();
    core_avl_t held1[$];
    bit        saw_r1;
    int        cyc;
    do_reset();
    port_en = 4'b1101;
    for (int p = 0; p < NP; p++) add_frame(p, 2, 1'b0);
    held1 = mdl_q[1];
    mdl_q[1].delete();
    build_expected(NP - 1);
    apply_inputs();
    saw_r1 = 1'b0;
    for (cyc = 0; cyc < 30; cyc++) begin
      step();
      if (s_in_ready[1]) saw_r1 = 1'b1;
    end
    n_cmp++;
    if (saw_r1 || src_q[1].size() != 2) begin
      n_err++;
      $display("FAIL dis_held: got ready_seen %b queued %0d, want 0 2", saw_r1, src_q[1].size());
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL dis_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k] || got_src[k] !== exp_src[k]) begin
        n_err++;
        $display("FAIL dis_beat[%0d]: got %h src %0d, want %h src %0d",
                 k, got_q[k], got_src[k], exp_q[k], exp_src[k]);
      end
    end
    port_en = 4'b1111;
    got_q.delete();
    got_src.delete();
    mdl_q[1] = held1;
    build_expected(NP - 1);
    drain(20);
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_src[0] !== 2'd1) begin
      n_err++;
      $display("FAIL dis_enable: got %0d beats first src %0d, want 2 beats src 1",
               got_q.size(), (got_src.size() > 0) ? got_src[0] : 2'd0);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    add_frame(0, 4, 1'b0);
    mdl_q[0].delete();
    apply_inputs();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    src_q[0].delete();
    apply_inputs();
    step();
    n_cmp++;
    if (s_out.valid !== 1'b0 || s_busy !== 1'b0 || s_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid: got vld %b busy %b cnt %0d, want 0 0 0",
               s_out.valid, s_busy, s_cnt);
    end
    got_q.delete();
    got_src.delete();
    add_frame(1, 2, 1'b0);
    add_frame(0, 2, 1'b0);
    build_expected(NP - 1);
    apply_inputs();
    drain(30);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rst_mid_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k] || got_src[k] !== exp_src[k]) begin
        n_err++;
        $display("FAIL rst_mid_beat[%0d]: got %h src %0d, want %h src %0d",
                 k, got_q[k], got_src[k], exp_q[k], exp_src[k]);
      end
    end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      do_reset();
      for (int p = 0; p < NP; p++) begin
        for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
          add_frame(p, int'($urandom_range(1, 5)), 1'b1);
        end
      end
      build_expected(NP - 1);
      rand_ready = 1'b1;
      apply_inputs();
      drain(2000);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL rand_count[%0d]: got %0d beats, want %0d",
                 it, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        n_cmp++;
        if (got_q[k] !== exp_q[k] || got_src[k] !== exp_src[k]) begin
          n_err++;
          $display("FAIL rand_beat[%0d.%0d]: got %h src %0d, want %h src %0d",
                   it, k, got_q[k], got_src[k], exp_q[k], exp_src[k]);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    port_en   = '1;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) in_avl[i] = '0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_orphan();
    test_disabled();
    test_reset_midframe();
    test_random(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
